rram_xbar_ctrl: RTL and testbench
=================================

Name: rram_xbar_ctrl

Overview:
- Command sequencer for the 1024x1024 RRAM crossbar macro, placed between a host command/response interface and the crossbar's WL/BL/WREN/RDEN/ADCSEL/ADCout pins.
- Turns a row-write command into a one-cycle one-hot WL + BL + WREN pulse.
- Turns a row-read command into an RDEN pulse, then sweeps ADCSEL 0..MUX_RATIO-1 and returns one packed 32-ADC word per select value over a valid/ready response stream.
- The crossbar's CLK and CLK_ADC are both tied to this block's CLK.

Parameters:
- NUM_ROWS, 1024, crossbar word lines; must be a power of 2.
- NUM_COLS, 1024, crossbar bit lines (BL width).
- NUM_ADCS, 32, ADC instances in the crossbar.
- ADC_BITS, 4, bits per ADC output.
- MUX_RATIO, 16, ADCSEL values per read sweep.
- SETTLE_CYCLES, 1, cycles ADCSEL is held before capture; legal range is 1 to 15.

Ports:
- CLK  in  1  single clock for the controller and crossbar (CLK and CLK_ADC).
- RESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  high only in IDLE with RESET deasserted.
- cmd_op  in  1  0 = write row, 1 = read row.
- cmd_row  in  $clog2(NUM_ROWS)  target row.
- cmd_data  in  NUM_COLS  write data; ignored for reads.
- rsp_valid  out  1  response word valid.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  NUM_ADCS*ADC_BITS  packed ADC outputs; ADC i occupies bits [i*ADC_BITS +: ADC_BITS].
- rsp_sel  out  4  ADCSEL value this word was captured with.
- rsp_last  out  1  high on the word with rsp_sel == MUX_RATIO-1.
- busy  out  1  high whenever state != IDLE.
- WL  out  NUM_ROWS  one-hot word-line select to crossbar.
- BL  out  NUM_COLS  bit-line write data to crossbar.
- WREN  out  1  crossbar write enable.
- RDEN  out  1  crossbar read enable.
- ADCSEL  out  4  crossbar ADC column select.
- adc_in  in  NUM_ADCS*ADC_BITS  crossbar ADCout, packed with ADC i at bits [i*ADC_BITS +: ADC_BITS].

Behaviour:
- Reset values: all outputs 0 (WL, BL, WREN, RDEN, ADCSEL, rsp_*, busy, cmd_ready); state = IDLE; select counter = 0; settle counter = 0.
- Reset asserted mid-operation aborts the operation immediately. Any pending response is dropped and no WREN/RDEN pulse is emitted afterwards.
- The command handshake fires on cmd_valid && cmd_ready. On that edge the block latches row, op and data, then goes to WRITE or READ.
- WRITE (1 cycle):
  - WL = one-hot(row), BL = data, WREN = 1.
  - The crossbar writes at the end of this cycle.
  - Next state is IDLE, with WL, BL and WREN returned to 0.
- READ (1 cycle):
  - WL = one-hot(row), RDEN = 1.
  - The crossbar loads its SL accumulators at the end of this cycle.
  - Select counter k is cleared to 0; next state is ADC_SET.
- ADC_SET (SETTLE_CYCLES cycles):
  - ADCSEL = k is driven; the crossbar ADC samples at the end of each cycle.
  - The settle counter counts down, then the state moves to CAPTURE.
- CAPTURE (1 cycle): adc_in is valid. At the end of the cycle rsp_data <= adc_in, rsp_sel <= k, rsp_last <= (k == MUX_RATIO-1). Next state is OUT.
- OUT:
  - rsp_valid = 1. rsp_data, rsp_sel and rsp_last stay stable until rsp_valid && rsp_ready.
  - On the handshake, if k == MUX_RATIO-1 the state goes to IDLE. Otherwise k increments and the state goes to ADC_SET.
  - rsp_valid never drops without a handshake.
- ADCSEL holds k in ADC_SET, CAPTURE and OUT, and is 0 in IDLE, WRITE and READ.
- WL, BL, WREN and RDEN are 0 outside WRITE/READ. WL is always one-hot or zero, because the crossbar decodes the highest set WL bit.
- Latency with SETTLE_CYCLES = 1 and rsp_ready tied high:
  - write: command handshake to WREN is 1 cycle; the block accepts the next command 2 cycles after the handshake.
  - read: first rsp_valid comes 4 cycles after the handshake; each following word takes 3 cycles; a full read lasts 2 + 3*MUX_RATIO cycles.
- No command is accepted while busy; back-pressure is applied through cmd_ready = 0.
- A stalled rsp_ready stalls the sweep in OUT indefinitely. The crossbar state is unaffected because no RDEN is issued.

Decomposition:
- Package rram_ctrl_pkg holds:
  - state_t enum {IDLE, WRITE, READ, ADC_SET, CAPTURE, OUT};
  - op_t enum {OP_WRITE = 0, OP_READ = 1};
  - localparams ROW_W = $clog2(NUM_ROWS) and ADCW = NUM_ADCS*ADC_BITS.
- Sub-module rram_wl_decoder: combinational ROW_W-to-NUM_ROWS one-hot decoder with an enable input; output is all zeros when disabled.

Test Plan:
- Write row 5, data = 1024'hA5...A5: WREN high exactly 1 cycle with WL = 1<<5 and BL = data; cmd_ready low that cycle and high the next.
- Write row 5, then read row 5, rsp_ready tied high: 16 words with rsp_sel 0..15; rsp_last only on sel 15. Each ADC nibble equals {3'b0, data[2*(16*i+sel)]}, i.e. 0 or 1. First rsp_valid 4 cycles after the read handshake.
- Read with rsp_ready low for 10 cycles on word 3: rsp_valid, rsp_data and rsp_sel = 3 stay stable; ADCSEL stays 3; no RDEN pulse during the stall.
- cmd_valid held high during a read sweep: cmd_ready stays 0 and the second command is accepted only in the cycle after the rsp_last handshake.
- RESET asserted in OUT at sel 7: all outputs 0 in the same cycle (asynchronous). After release, busy = 0 and a new write is accepted normally.
- Write row 1023 (MSB) and row 0: WL one-hot at the correct extreme bit; a readback of each row returns only that row's data.

Source files
------------

// File: rtl/rram_xbar_ctrl_pkg.sv
// Shared types and default geometry for the RRAM crossbar controller.
package rram_ctrl_pkg;

  localparam int DEF_NUM_ROWS      = 1024;
  localparam int DEF_NUM_COLS      = 1024;
  localparam int DEF_NUM_ADCS      = 32;
  localparam int DEF_ADC_BITS      = 4;
  localparam int DEF_MUX_RATIO     = 16;
  localparam int DEF_SETTLE_CYCLES = 1;

  localparam int ROW_W = $clog2(DEF_NUM_ROWS);
  localparam int ADCW  = DEF_NUM_ADCS * DEF_ADC_BITS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    ADC_SET = 3'd3,
    CAPTURE = 3'd4,
    OUT     = 3'd5
  } state_t;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_t;

endpackage

// File: rtl/rram_wl_decoder.sv
// Row address to one-hot word-line decoder; all zeros when not enabled.
module rram_wl_decoder
  import rram_ctrl_pkg::*;
#(
  parameter int ROWS = DEF_NUM_ROWS,
  parameter int RW   = $clog2(ROWS)
) (
  input  logic            en,
  input  logic [RW-1:0]   row,
  output logic [ROWS-1:0] wl
);

  always_comb begin
    wl = '0;
    if (en) wl[row] = 1'b1;
  end

endmodule

// File: rtl/rram_xbar_ctrl.sv
// Command sequencer for the RRAM crossbar: one-cycle row writes, and row reads
// swept across every ADC select value with a valid/ready response stream.
module rram_xbar_ctrl
  import rram_ctrl_pkg::*;
#(
  parameter int NUM_ROWS      = DEF_NUM_ROWS,
  parameter int NUM_COLS      = DEF_NUM_COLS,
  parameter int NUM_ADCS      = DEF_NUM_ADCS,
  parameter int ADC_BITS      = DEF_ADC_BITS,
  parameter int MUX_RATIO     = DEF_MUX_RATIO,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_op,
  input  logic [$clog2(NUM_ROWS)-1:0]  cmd_row,
  input  logic [NUM_COLS-1:0]          cmd_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [NUM_ADCS*ADC_BITS-1:0] rsp_data,
  output logic [3:0]                   rsp_sel,
  output logic                         rsp_last,
  output logic                         busy,
  output logic [NUM_ROWS-1:0]          WL,
  output logic [NUM_COLS-1:0]          BL,
  output logic                         WREN,
  output logic                         RDEN,
  output logic [3:0]                   ADCSEL,
  input  logic [NUM_ADCS*ADC_BITS-1:0] adc_in
);

  localparam int         RW          = $clog2(NUM_ROWS);
  localparam logic [3:0] LAST_SEL    = 4'(MUX_RATIO - 1);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  // Handshakes: a transfer happens on a rising CLK edge where valid && ready;
  // valid never drops and payload never changes until that transfer.
  state_t               state, state_nxt;
  logic [3:0]           sel_q, sel_nxt;
  logic [3:0]           settle_q, settle_nxt;
  logic [RW-1:0]        row_q;
  logic [NUM_COLS-1:0]  data_q;
  logic                 cmd_fire, rsp_fire;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      sel_q    <= '0;
      settle_q <= '0;
      row_q    <= '0;
      data_q   <= '0;
      rsp_data <= '0;
      rsp_sel  <= '0;
      rsp_last <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel_q    <= sel_nxt;
      settle_q <= settle_nxt;
      if (cmd_fire) begin
        row_q  <= cmd_row;
        data_q <= cmd_data;
      end
      if (state == CAPTURE) begin
        rsp_data <= adc_in;
        rsp_sel  <= sel_q;
        rsp_last <= (sel_q == LAST_SEL);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel_q;
    settle_nxt = settle_q;
    case (state)
      IDLE: begin
        if (cmd_fire) state_nxt = (op_t'(cmd_op) == OP_READ) ? READ : WRITE;
      end
      WRITE: state_nxt = IDLE;
      READ: begin
        sel_nxt    = '0;
        settle_nxt = SETTLE_INIT;
        state_nxt  = ADC_SET;
      end
      ADC_SET: begin
        if (settle_q == '0) state_nxt = CAPTURE;
        else                settle_nxt = settle_q - 4'd1;
      end
      CAPTURE: state_nxt = OUT;
      OUT: begin
        if (rsp_fire) begin
          if (sel_q == LAST_SEL) begin
            state_nxt = IDLE;
          end else begin
            sel_nxt    = sel_q + 4'd1;
            settle_nxt = SETTLE_INIT;
            state_nxt  = ADC_SET;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Everything facing the crossbar is decoded from state, so an asynchronous
  // reset clears it in the same cycle.
  assign cmd_ready = (state == IDLE) && !RESET;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == OUT);
  assign WREN      = (state == WRITE);
  assign RDEN      = (state == READ);
  assign BL        = WREN ? data_q : '0;
  assign ADCSEL    = (state == ADC_SET || state == CAPTURE || state == OUT) ? sel_q : 4'd0;

  rram_wl_decoder #(
    .ROWS (NUM_ROWS),
    .RW   (RW)
  ) u_wl_decoder (
    .en  (WREN || RDEN),
    .row (row_q),
    .wl  (WL)
  );

endmodule

// File: tb/tb_rram_xbar_ctrl.sv
// Bench for rram_xbar_ctrl: behavioural crossbar plus a command-level memory
// model that predicts every response word.
module tb_rram_xbar_ctrl;
  import rram_ctrl_pkg::*;

  localparam int NR  = 1024;
  localparam int NC  = 1024;
  localparam int MUX = 16;
  localparam int EW  = ADCW + 5;

  logic             CLK, RESET;
  logic             cmd_valid, cmd_ready, cmd_op;
  logic [ROW_W-1:0] cmd_row;
  logic [NC-1:0]    cmd_data;
  logic             rsp_valid, rsp_ready, rsp_last, busy;
  logic [ADCW-1:0]  rsp_data, adc_in;
  logic [3:0]       rsp_sel, ADCSEL;
  logic [NR-1:0]    WL;
  logic [NC-1:0]    BL;
  logic             WREN, RDEN;

  rram_xbar_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_sel(rsp_sel), .rsp_last(rsp_last), .busy(busy),
    .WL(WL), .BL(BL), .WREN(WREN), .RDEN(RDEN), .ADCSEL(ADCSEL),
    .adc_in(adc_in)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Crossbar: writes/reads the row of the highest set WL bit, ADC samples each edge
  logic [NC-1:0] xbar_mem [NR];
  logic [NC-1:0] sl_acc;
  logic          mem_clr;
  int            xb_hi;

  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int r = 0; r < NR; r++) xbar_mem[r] <= '0;
      sl_acc <= '0;
      adc_in <= '0;
    end else begin
      xb_hi = -1;
      for (int r = 0; r < NR; r++) if (WL[r]) xb_hi = r;
      if (WREN && xb_hi >= 0) xbar_mem[xb_hi] <= BL;
      if (RDEN && xb_hi >= 0) sl_acc <= xbar_mem[xb_hi];
      for (int i = 0; i < 32; i++)
        adc_in[i*4 +: 4] <= {3'b000, sl_acc[2*(16*i + int'(ADCSEL))]};
    end
  end

  // Reference model and scoreboard
  logic [NC-1:0]    ref_mem [NR];
  logic [EW-1:0]    exp_q[$];
  int               n_checks, n_errors;
  logic [ROW_W-1:0] hold_row;
  logic [NC-1:0]    hold_data;

  function automatic logic [EW-1:0] exp_word(input logic [NC-1:0] d, input int s);
    logic [ADCW-1:0] w;
    for (int i = 0; i < 32; i++) w[i*4 +: 4] = {3'b000, d[2*(16*i + s)]};
    return {w, 4'(s), (s == MUX - 1)};
  endfunction

  function automatic logic [NR-1:0] onehot(input logic [ROW_W-1:0] row);
    logic [NR-1:0] v;
    v = '0;
    v[row] = 1'b1;
    return v;
  endfunction

  function automatic logic [NC-1:0] rand_data();
    logic [NC-1:0] d;
    for (int j = 0; j < NC / 32; j++) d[j*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int fd;
    fd = -1;
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      for (int b = 1023; b >= 0; b--) if (obs[b] !== exp[b]) fd = b;
      $error("FAIL %s: observed 'h%0h expected 'h%0h (low 256 bits, first differing bit %0d)",
             tag, obs[255:0], exp[255:0], fd);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_sel"}, rsp_sel, 0);
    chk({tag, "_rsp_last"}, rsp_last, 0);
    chk({tag, "_wl"}, WL, 0);
    chk({tag, "_bl"}, BL, 0);
    chk({tag, "_wren"}, WREN, 0);
    chk({tag, "_rden"}, RDEN, 0);
    chk({tag, "_adcsel"}, ADCSEL, 0);
  endtask

  // Driver tasks: called at a negedge, return at a negedge
  task automatic send_cmd(input logic op, input logic [ROW_W-1:0] row, input logic [NC-1:0] data);
    int w;
    w = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_data = data;
    while (!cmd_ready && w < 200) begin
      @(negedge CLK);
      w++;
    end
    chk("cmd_accept_timeout", cmd_ready, 1);
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [ROW_W-1:0] row, input logic [NC-1:0] data);
    send_cmd(1'b0, row, data);
    ref_mem[row] = data;
    chk("wr_wren", WREN, 1);
    chk("wr_rden", RDEN, 0);
    chk("wr_wl", WL, onehot(row));
    chk("wr_bl", BL, data);
    chk("wr_cmd_ready_low", cmd_ready, 0);
    @(negedge CLK);
    chk("wr_wren_off", WREN, 0);
    chk("wr_wl_off", WL, 0);
    chk("wr_bl_off", BL, 0);
    chk("wr_cmd_ready_back", cmd_ready, 1);
  endtask

  // mode 0: rsp_ready high except the stall; mode 1: random rsp_ready
  task automatic do_read(input logic [ROW_W-1:0] row, input int mode, input int stall_word,
                         input int abort_sel, input bit hold);
    int cyc, got, last_hs, stall_left;
    bit first_seen, prev_stalled, rdy;
    logic [ADCW-1:0] prev_data;
    logic [3:0]      prev_sel;
    logic [EW-1:0]   e;
    cyc = 1; got = 0; last_hs = 0; stall_left = 10;
    first_seen = 0; prev_stalled = 0; prev_data = '0; prev_sel = '0;
    for (int s = 0; s < MUX; s++) exp_q.push_back(exp_word(ref_mem[row], s));
    send_cmd(1'b1, row, '0);
    if (hold) begin
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_row = hold_row; cmd_data = hold_data;
    end
    chk("rd_rden", RDEN, 1);
    chk("rd_wren", WREN, 0);
    chk("rd_wl", WL, onehot(row));
    while (got < MUX && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
      chk("rd_no_rden", RDEN, 0);
      chk("rd_cmd_ready_low", cmd_ready, 0);
      chk("rd_wl_zero", WL, 0);
      if (prev_stalled) begin
        chk("stall_valid", rsp_valid, 1);
        chk("stall_data", rsp_data, prev_data);
        chk("stall_sel", rsp_sel, prev_sel);
        chk("stall_adcsel", ADCSEL, prev_sel);
      end
      if (rsp_valid) begin
        if (!first_seen) chk("first_latency", cyc, 4);
        else if (mode == 0 && !prev_stalled) chk("word_gap", cyc - last_hs, 3);
        first_seen = 1;
        if (int'(rsp_sel) == abort_sel) begin
          rsp_ready = 1'b0;
          #2 RESET = 1'b1;
          #1 chk_all_zero("abort");
          @(negedge CLK);
          RESET = 1'b0;
          #1;
          chk("abort_busy", busy, 0);
          chk("abort_cmd_ready", cmd_ready, 1);
          exp_q.delete();
          return;
        end
        if (got == stall_word && stall_left > 0) begin
          rdy = 0;
          stall_left--;
        end else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
        else rdy = 1;
        rsp_ready = rdy;
        if (rdy) begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e[EW-1:5]);
          chk("rsp_sel", rsp_sel, e[4:1]);
          chk("rsp_last", rsp_last, e[0]);
          got++;
          last_hs = cyc;
        end
        prev_stalled = !rdy;
        prev_data = rsp_data;
        prev_sel = rsp_sel;
      end else begin
        rsp_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_stalled = 0;
      end
    end
    chk("rd_words", got, MUX);
    if (mode == 0 && stall_word < 0) chk("rd_total_cycles", last_hs, 1 + 3 * MUX);
    @(negedge CLK);
    chk("rd_busy_done", busy, 0);
    chk("rd_cmd_ready_done", cmd_ready, 1);
    if (hold) begin
      @(negedge CLK);
      cmd_valid = 1'b0;
      ref_mem[hold_row] = hold_data;
      chk("hold_wren", WREN, 1);
      chk("hold_wl", WL, onehot(hold_row));
      chk("hold_bl", BL, hold_data);
      @(negedge CLK);
    end
  endtask

  initial begin
    logic [NC-1:0]    d_a5, d0, d1, dr;
    logic [ROW_W-1:0] r;
    n_checks = 0; n_errors = 0;
    RESET = 1'b1; mem_clr = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_row = '0; cmd_data = '0; rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) ref_mem[i] = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");
    RESET = 1'b0; mem_clr = 1'b0;
    #1 chk("reset_release_ready", cmd_ready, 1);
    @(negedge CLK);

    // Write then read row 5
    d_a5 = {128{8'hA5}};
    do_write(10'd5, d_a5);
    do_read(10'd5, 0, -1, 99, 0);

    // Stall word 3 for 10 cycles
    do_read(10'd5, 0, 3, 99, 0);

    // Command held during a read sweep
    hold_row = 10'd77;
    hold_data = rand_data();
    do_read(10'd5, 0, -1, 99, 1);
    do_read(10'd77, 0, -1, 99, 0);

    // Reset in OUT at sel 7
    do_read(10'd5, 0, -1, 7, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("post_abort_wren", WREN, 0);
      chk("post_abort_rden", RDEN, 0);
      chk("post_abort_valid", rsp_valid, 0);
    end
    do_write(10'd9, rand_data());
    do_read(10'd9, 0, -1, 99, 0);

    // Extreme rows
    d0 = rand_data();
    d1 = rand_data();
    do_write(10'd1023, d1);
    do_write(10'd0, d0);
    do_read(10'd1023, 0, -1, 99, 0);
    do_read(10'd0, 0, -1, 99, 0);

    // Randomized writes/reads with random back-pressure
    for (int it = 0; it < 8; it++) begin
      r = 10'($urandom_range(0, NR - 1));
      dr = rand_data();
      do_write(r, dr);
      if ($urandom_range(0, 1) == 1) r = 10'($urandom_range(0, NR - 1));
      do_read(r, 1, -1, 99, 0);
    end
    do_read(10'd5, 1, -1, 99, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
